// File: rtl/vend_apb_cfg_master_pkg.sv
// vend_apb_cfg_master_pkg
//   Shared types and constants for the vending item-configuration APB master.
//   - state_t       : command FSM states
//   - *_LSB         : bit offsets of the fields inside a 32-bit item word
//   - DEFAULT_ITEM  : item word a freshly initialised entry holds
//   - item_word()   : packs sold/stock/price into an item word
package vend_apb_cfg_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int PRICE_LSB = 0;
    localparam int STOCK_LSB = 16;
    localparam int SOLD_LSB  = 24;

    // sold = 0, stock = 100, price = 10
    localparam logic [31:0] DEFAULT_ITEM = {8'd0, 8'd100, 16'h000A};

    function automatic logic [31:0] item_word(input logic [7:0]  sold,
                                               input logic [7:0]  stock,
                                               input logic [15:0] price);
        logic [31:0] w;
        w = '0;
        w[SOLD_LSB  +: 8]  = sold;
        w[STOCK_LSB +: 8]  = stock;
        w[PRICE_LSB +: 16] = price;
        return w;
    endfunction

endpackage

// File: rtl/vend_cmd_fifo.sv
// vend_cmd_fifo
//   Synchronous command queue, read-ahead (head word visible on rdata while
//   !empty). Read/write pointers plus an occupancy count; push and pop may
//   occur in the same cycle. Pushes while full and pops while empty are ignored.
//   Ports:
//     pclk, prstn      clock, async active-low reset (flushes the queue)
//     push, wdata      enqueue request and word
//     pop              dequeue the head word
//     rdata            head word
//     full, empty      occupancy flags
module vend_cmd_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             pclk,
    input  logic             prstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vend_apb_cfg_master.sv
// vend_apb_cfg_master
//   APB initiator for the vending core's per-item configuration table.
//   Item-level commands are queued, each becomes one APB SETUP/ACCESS
//   transfer, and one response is returned per command, in order.
//   Ports:
//     pclk, prstn                      APB clock, async active-low reset
//     cmd_valid/ready/write/index/wdata command stream (ready = queue not full)
//     rsp_valid/ready/rdata/err        response stream
//     psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
//                                      APB initiator port (word-index paddr)
//     busy                             transfer in flight or queue non-empty
module vend_apb_cfg_master
    import vend_apb_cfg_master_pkg::*;
#(
    parameter int ITEMS      = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                     pclk,
    input  logic                     prstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [$clog2(ITEMS)-1:0] cmd_index,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [31:0]              paddr,
    output logic [31:0]              pwdata,
    input  logic [31:0]              prdata,
    input  logic                     pready,
    input  logic                     pslverr,
    output logic                     busy
);

    localparam int IDX_W = $clog2(ITEMS);
    localparam int CMD_W = 1 + IDX_W + 32;

    state_t           state;
    state_t           state_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    logic [4:0]       wait_cnt;
    logic             timeout_hit;

    assign cmd_ready = !fifo_full;

    vend_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk  (pclk),
        .prstn (prstn),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_write, cmd_index, cmd_wdata}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign timeout_hit = (wait_cnt == 5'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Decoded straight from the state register so reset drops them at once.
    assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable   = (state == ST_ACCESS);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    // Address/control/data are loaded only on a pop, so they stay stable
    // through SETUP/ACCESS and linger afterwards until the next command.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (fifo_pop) begin
            pwrite <= fifo_head[CMD_W-1];
            paddr  <= 32'(fifo_head[32 +: IDX_W]);
            pwdata <= fifo_head[31:0];
        end
    end

    // Cleared on entry to ACCESS (i.e. while in SETUP), saturating.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && (wait_cnt != 5'h1F)) begin
            wait_cnt <= wait_cnt + 5'd1;
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (pready) begin
                rsp_rdata <= pwrite ? 32'd0 : prdata;
                rsp_err   <= pslverr;
            end else if (timeout_hit) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule
